// File: rtl/aes_buf_pkg.sv
// aes_buf_pkg: shared byte/block types and chunk drain-order helper for the AES output buffers
package aes_buf_pkg;
  localparam int AES_BLK_BYTES = 16;
  typedef logic [7:0] byte_t;
  typedef byte_t [AES_BLK_BYTES-1:0] aes_blk_t;
  function automatic int chunk_sel(input int ptr, input logic order, input int nchunk);
    return order ? nchunk - 1 - ptr : ptr;
  endfunction
endpackage

// File: rtl/mod_preg_p2s_if.sv
// mod_preg_p2s_if: load/pop/status bundle of the parallel-to-serial block buffer
interface mod_preg_p2s_if import aes_buf_pkg::*; #(
  parameter int NBYTES = 16,
  parameter int OUT_BYTES = 1
) ();
  logic wr_en, msb_first, wr_ready, req_fifo, o_valid;
  logic reg_empty, reg_full, err_ovf, err_udf;
  logic [1:0] blk_cnt;
  byte_t [NBYTES-1:0] i;
  byte_t [OUT_BYTES-1:0] o;
  modport master(
    output wr_en, i, msb_first, req_fifo,
    input wr_ready, o, o_valid, reg_empty, reg_full, blk_cnt, err_ovf, err_udf
  );
  modport slave(
    input wr_en, i, msb_first, req_fifo,
    output wr_ready, o, o_valid, reg_empty, reg_full, blk_cnt, err_ovf, err_udf
  );
endinterface

// File: rtl/mod_p2s_slot.sv
// mod_p2s_slot: one block slot with valid/order bits and a chunk read mux
module mod_p2s_slot import aes_buf_pkg::*; #(
  parameter int NBYTES = 16,
  parameter int OUT_BYTES = 1,
  localparam int NCHUNK = NBYTES / OUT_BYTES,
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic order_in,
  input  byte_t [NBYTES-1:0] d,
  input  logic [CW-1:0] idx,
  output logic valid,
  output logic order,
  output byte_t [OUT_BYTES-1:0] chunk
);
  byte_t [NBYTES-1:0] data;
  always_ff @(posedge clk)
    if (rst) begin
      data <= '0;
      valid <= 1'b0;
      order <= 1'b0;
    end else if (load) begin
      data <= d;
      valid <= 1'b1;
      order <= order_in;
    end else if (clr) valid <= 1'b0;
  assign chunk = data[int'(idx)*OUT_BYTES +: OUT_BYTES];
endmodule

// File: rtl/mod_preg_p2s.sv
// mod_preg_p2s: ping-pong block buffer draining OUT_BYTES per pop in per-block order
module mod_preg_p2s import aes_buf_pkg::*; #(
  parameter int NBYTES = 16,
  parameter int OUT_BYTES = 1
) (
  input logic clk,
  input logic resetn,
  mod_preg_p2s_if.slave bus
);
  localparam int NCHUNK = NBYTES / OUT_BYTES;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  logic head, tail, do_load, do_pop, last;
  logic [CW-1:0] ptr, c;
  logic [1:0] cnt, valid, ord;
  byte_t [OUT_BYTES-1:0] chunk [2];
  assign tail = head ^ (cnt == 2'd1);
  assign do_load = bus.wr_en && bus.wr_ready;
  assign do_pop = bus.req_fifo && valid[head];
  assign last = int'(ptr) == NCHUNK - 1;
  assign c = CW'(chunk_sel(int'(ptr), ord[head], NCHUNK));
  assign bus.wr_ready = !resetn && cnt != 2'd2;
  assign bus.reg_empty = cnt == 2'd0;
  assign bus.reg_full = cnt == 2'd2;
  assign bus.blk_cnt = cnt;
  for (genvar s = 0; s < 2; s++) begin : g_slot
    mod_p2s_slot #(.NBYTES(NBYTES), .OUT_BYTES(OUT_BYTES)) u_slot (
      .clk(clk),
      .rst(resetn),
      .load(do_load && tail == 1'(s)),
      .clr(do_pop && last && head == 1'(s)),
      .order_in(bus.msb_first),
      .d(bus.i),
      .idx(c),
      .valid(valid[s]),
      .order(ord[s]),
      .chunk(chunk[s])
    );
  end
  // the load/free pair nets to zero on blk_cnt when both land on one edge
  always_ff @(posedge clk)
    if (resetn) begin
      head <= 1'b0;
      ptr <= '0;
      cnt <= 2'd0;
      bus.o <= '0;
      bus.o_valid <= 1'b0;
      bus.err_ovf <= 1'b0;
      bus.err_udf <= 1'b0;
    end else begin
      bus.o_valid <= do_pop;
      if (do_pop) begin
        bus.o <= chunk[head];
        ptr <= last ? '0 : ptr + CW'(1);
        head <= head ^ last;
      end
      cnt <= cnt + 2'(do_load) - 2'(do_pop && last);
      if (bus.wr_en && !bus.wr_ready) bus.err_ovf <= 1'b1;
      if (bus.req_fifo && !valid[head]) bus.err_udf <= 1'b1;
    end
endmodule

// File: tb/tb_mod_preg_p2s.sv
// tb_mod_preg_p2s: table-driven and randomized checks of two buffer configurations (1- and 4-byte pops)
module tb_mod_preg_p2s;
  import aes_buf_pkg::*;
  typedef struct {
    logic r, w, m, q;
    logic [7:0] base, mul, eo8;
    logic ev;
    logic [1:0] ecnt;
    logic eov, eud;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1, wr_en = 1'b0, msb = 1'b0, req = 1'b0;
  byte_t [15:0] din = '0;
  int nchk = 0, nerr = 0;
  vec_t tbl[$];
  int cur_eo, cur_eu;
  logic [127:0] mbuf [2][32];
  int mhead [2], mcnt [2];
  logic [127:0] expo [2];
  logic expv [2], eeo [2], eeu [2];
  always #5 clk = ~clk;
  mod_preg_p2s_if #(.NBYTES(16), .OUT_BYTES(1)) b1 ();
  mod_preg_p2s_if #(.NBYTES(16), .OUT_BYTES(4)) b4 ();
  assign b1.wr_en = wr_en;
  assign b1.msb_first = msb;
  assign b1.req_fifo = req;
  assign b1.i = din;
  assign b4.wr_en = wr_en;
  assign b4.msb_first = msb;
  assign b4.req_fifo = req;
  assign b4.i = din;
  mod_preg_p2s #(.NBYTES(16), .OUT_BYTES(1)) u1 (.clk(clk), .resetn(rst), .bus(b1));
  mod_preg_p2s #(.NBYTES(16), .OUT_BYTES(4)) u4 (.clk(clk), .resetn(rst), .bus(b4));
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic chk_dut(input int d, input logic [127:0] o, input logic v, input logic [1:0] cnt,
                         input logic emp, input logic full, input logic rdy, input logic eo, input logic eu);
    int nc, blk;
    string p;
    nc = d ? 4 : 16;
    blk = (mcnt[d] + nc - 1) / nc;
    p = d ? "u4" : "u1";
    chk({p, ".o"}, o, expo[d]);
    chk({p, ".o_valid"}, 128'(v), 128'(expv[d]));
    chk({p, ".blk_cnt"}, 128'(cnt), 128'(blk));
    chk({p, ".reg_empty"}, 128'(emp), 128'(blk == 0));
    chk({p, ".reg_full"}, 128'(full), 128'(blk == 2));
    chk({p, ".wr_ready"}, 128'(rdy), 128'(!rst && blk < 2));
    chk({p, ".err_ovf"}, 128'(eo), 128'(eeo[d]));
    chk({p, ".err_udf"}, 128'(eu), 128'(eeu[d]));
  endtask
  // reference: each block becomes its list of output chunks in drain order, held in a FIFO
  task automatic step(input logic r, input logic w, input logic m, input logic q, input byte_t [15:0] d);
    logic ld [2], pp [2], rdy [2];
    rst = r; wr_en = w; msb = m; req = q; din = d;
    for (int k = 0; k < 2; k++) begin
      int nc = k ? 4 : 16;
      rdy[k] = !r && (mcnt[k] + nc - 1) / nc < 2;
      ld[k] = w && rdy[k];
      pp[k] = !r && q && mcnt[k] > 0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      int nc = k ? 4 : 16, ob = k ? 4 : 1;
      if (r) begin
        mcnt[k] = 0; mhead[k] = 0; expo[k] = '0; expv[k] = 1'b0; eeo[k] = 1'b0; eeu[k] = 1'b0;
      end else begin
        if (w && !rdy[k]) eeo[k] = 1'b1;
        if (q && mcnt[k] == 0) eeu[k] = 1'b1;
        expv[k] = pp[k];
        if (pp[k]) begin
          expo[k] = mbuf[k][mhead[k]];
          mhead[k] = (mhead[k] + 1) % 32;
          mcnt[k]--;
        end
        if (ld[k])
          for (int n = 0; n < nc; n++) begin
            int cc = m ? nc - 1 - n : n;
            logic [127:0] ch = '0;
            for (int j = 0; j < ob; j++) ch[8*j +: 8] = d[cc*ob + j];
            mbuf[k][(mhead[k] + mcnt[k]) % 32] = ch;
            mcnt[k]++;
          end
      end
    end
    chk_dut(0, 128'(b1.o), b1.o_valid, b1.blk_cnt, b1.reg_empty, b1.reg_full, b1.wr_ready, b1.err_ovf, b1.err_udf);
    chk_dut(1, 128'(b4.o), b4.o_valid, b4.blk_cnt, b4.reg_empty, b4.reg_full, b4.wr_ready, b4.err_ovf, b4.err_udf);
  endtask
  task automatic add(input int r, input int w, input int m, input int q, input int base, input int mul,
                     input int o, input int v, input int cnt);
    tbl.push_back('{1'(r), 1'(w), 1'(m), 1'(q), 8'(base), 8'(mul), 8'(o), 1'(v), 2'(cnt), 1'(cur_eo), 1'(cur_eu)});
  endtask
  initial begin
    logic [31:0] e4 [4];
    byte_t [15:0] d;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mhead[k] = 0; expo[k] = '0; expv[k] = 1'b0; eeo[k] = 1'b0; eeu[k] = 1'b0;
    end
    cur_eo = 0; cur_eu = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      add(0, 0, 0, 1, 0, 0, k, 1, k == 15 ? 0 : 1);
      add(0, 0, 0, 0, 0, 0, k, 0, k == 15 ? 0 : 1);
    end
    add(0, 1, 1, 0, 0, 2, 'h0F, 0, 1);
    for (int k = 0; k < 16; k++) add(0, 0, 0, 1, 0, 0, 2 * (15 - k), 1, k == 15 ? 0 : 1);
    add(0, 1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 'h40, 1, 0, 0, 2);
    cur_eo = 1;
    add(0, 1, 0, 0, 'h80, 1, 0, 0, 2);
    for (int k = 0; k < 32; k++) add(0, 0, 0, 1, 0, 0, k < 16 ? k : 'h40 + k - 16, 1, k < 15 ? 2 : (k < 31 ? 1 : 0));
    cur_eo = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 15; k++) add(0, 0, 0, 1, 0, 0, k, 1, 1);
    add(0, 1, 0, 1, 'h40, 1, 'h0F, 1, 1);
    for (int k = 0; k < 16; k++) add(0, 0, 0, 1, 0, 0, 'h40 + k, 1, k == 15 ? 0 : 1);
    cur_eu = 1;
    add(0, 0, 0, 1, 0, 0, 'h4F, 0, 0);
    add(0, 1, 0, 0, 'h10, 1, 'h4F, 0, 1);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 1, 0, 0, 'h10 + k, 1, 1);
    cur_eu = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cur_eu = 1;
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    foreach (tbl[n]) begin
      for (int k = 0; k < 16; k++) d[k] = tbl[n].base + tbl[n].mul * 8'(k);
      step(tbl[n].r, tbl[n].w, tbl[n].m, tbl[n].q, d);
      chk($sformatf("vec%0d.o", n), 128'(b1.o), 128'(tbl[n].eo8));
      chk($sformatf("vec%0d.o_valid", n), 128'(b1.o_valid), 128'(tbl[n].ev));
      chk($sformatf("vec%0d.blk_cnt", n), 128'(b1.blk_cnt), 128'(tbl[n].ecnt));
      chk($sformatf("vec%0d.err_ovf", n), 128'(b1.err_ovf), 128'(tbl[n].eov));
      chk($sformatf("vec%0d.err_udf", n), 128'(b1.err_udf), 128'(tbl[n].eud));
    end
    e4[0] = 32'h0C080400; e4[1] = 32'h1C181410; e4[2] = 32'h2C282420; e4[3] = 32'h3C383430;
    for (int k = 0; k < 16; k++) d[k] = 8'(4 * k);
    step(1, 0, 0, 0, d);
    step(0, 1, 0, 0, d);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, d);
      chk($sformatf("ob4.pop%0d", k), 128'(b4.o), 128'(e4[k]));
    end
    chk("ob4.drained", 128'(b4.reg_empty), 128'(1));
    step(1, 0, 0, 0, d);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 1'($urandom), $urandom_range(0, 9) < 6, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
